vv_update_scheduler: RTL and testbench
======================================

Name: vv_update_scheduler

Overview:
- Schedules writes from two requesters into one shared W-bit register `x` within a single time step.
- Requester 1 is a blocking (active-region) writer; requester 2 is a non-blocking (NBA-region) writer.
- A watcher process increments `x` whenever `x[0]` changes.
- A parameter selects the watcher semantics:
  - correct: the watcher does not retrigger on its own write;
  - faulty: the watcher does retrigger on its own write, which emulates a runaway propagation loop. An iteration bound catches this case.

Parameters:
- W, 16, width of `x` and of both data inputs.
- MAX_ITER, 8, maximum watcher increments per time step before abort.
- RETRIGGER_SELF, 0, 1 selects the faulty semantics (watcher re-senses its own write).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a time step; sampled only in IDLE.
- blk_valid  input  1  a blocking write is requested this step; sampled with `start`.
- blk_data  input  W  blocking write value; sampled with `start`.
- nba_valid  input  1  a non-blocking write is requested this step; sampled with `start`.
- nba_data  input  W  non-blocking write value; sampled with `start`.
- x  output  W  the shared register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the time step completes.
- loop_err  output  1  sticky; set on iteration overflow, cleared on the next accepted `start`.
- iter_cnt  output  $clog2(MAX_ITER+1)  watcher increments in the current or last step.

Behaviour:
- Reset (asynchronous, rst_n=0) clears: `x`, `x0_seen`, the NBA pending flag and data, `iter_cnt`, `loop_err`, `done`, and `busy`. State goes to IDLE.
- `x0_seen` is the watcher's internal copy of the last `x[0]` value it has sensed.
- States: IDLE, ACTIVE, WATCH1, NBA, WATCH2, DONE.
- IDLE:
  - `start`=1 captures `blk_valid`/`blk_data` and `nba_valid`/`nba_data` into internal registers.
  - It also clears `iter_cnt` and `loop_err`, then goes to ACTIVE.
  - `start` in any other state is ignored.
- ACTIVE:
  - If the captured `blk_valid` is set, `x <= blk_data`.
  - Always goes to WATCH1.
- WATCH1 / WATCH2, one check per cycle:
  - If `x[0] != x0_seen` and `iter_cnt == MAX_ITER`: set `loop_err`, leave `x` unchanged, go to DONE.
  - Else if `x[0] != x0_seen`:
    - `x <= x + 1`, wrapping mod 2^W (for W=1, 1+1 gives 0);
    - `iter_cnt++`;
    - `x0_seen <= ~x[0]` when RETRIGGER_SELF=0 (the watcher absorbs its own write);
    - `x0_seen <= x[0]` when RETRIGGER_SELF=1 (the new `x[0]` differs again, so the watcher fires again);
    - stay in the current WATCH state.
  - Else (stable), WATCH1 goes to NBA if the captured `nba_valid` is set, otherwise to DONE.
  - Else (stable), WATCH2 goes to DONE.
- NBA: `x <= nba_data`, then go to WATCH2.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `x`, `iter_cnt` and `loop_err` hold until the next `start`.
- Writes to `x` by ACTIVE/NBA never update `x0_seen`. Only the watcher updates it.
- Blocking and NBA writes in the same step: the blocking write and its propagation always complete before the NBA write is applied.
- Minimum step latency, with no watcher activity:
  - `start` accepted in cycle t, ACTIVE at t+1, WATCH1 at t+2;
  - with no NBA write: DONE at t+3;
  - with an NBA write: NBA at t+3, WATCH2 at t+4, DONE at t+5.
  - Each watcher increment adds 1 cycle.
- Reset asserted mid-step aborts immediately. No `done` pulse is produced; all state returns to its reset value.

Test Plan:
- W=16, RETRIGGER_SELF=0:
  - Stimulus: reset, then `start` with blk=0 and nba=2.
  - Required: `x`=2, `iter_cnt`=0, `loop_err`=0; `done` is seen 5 cycles after `start`.
- W=1, RETRIGGER_SELF=0:
  - Stimulus: `start` with blk=0 and nba=1.
  - Required: NBA sets `x`=1; the watcher fires once and `x` wraps to 0; `iter_cnt`=1, `loop_err`=0.
- W=16, RETRIGGER_SELF=1, MAX_ITER=8:
  - Stimulus: `start` with nba=3 only.
  - Required: `x` steps through 4 to 11; `loop_err`=1, `iter_cnt`=8, `x`=11; `done` pulses.
- W=16, RETRIGGER_SELF=0:
  - Stimulus: `start` with blk=5 and no NBA write.
  - Required: WATCH1 increments once to `x`=6; `iter_cnt`=1; no NBA state is entered.
- Stimulus: `start` while `busy`, then `rst_n` pulsed low while in WATCH2.
  - Required: the mid-step `start` is ignored.
  - After reset: `x`=0, `busy`=0, `done` never pulsed, `loop_err`=0.
- Back-to-back steps:
  - Stimulus: a step ending with `loop_err`=1, followed by a clean step (RETRIGGER_SELF=1, then nba=2).
  - Required: `loop_err` clears on accept; `x`=2, `iter_cnt`=0.

Source files
------------

// File: rtl/vv_update_scheduler_if.sv
// Bus bundle for vv_update_scheduler: step request with captured write operands,
// plus the shared register and step status.
interface vv_update_scheduler_if #(
    parameter int W        = 16,
    parameter int MAX_ITER = 8
);
    localparam int IW = $clog2(MAX_ITER + 1);

    // Handshake: start is a request sampled only while busy=0; blk_*/nba_* are captured
    // with it, later starts are dropped until done has pulsed for one cycle and busy falls.
    logic          start;
    logic          blk_valid;
    logic [W-1:0]  blk_data;
    logic          nba_valid;
    logic [W-1:0]  nba_data;
    logic [W-1:0]  x;
    logic          busy;
    logic          done;
    logic          loop_err;
    logic [IW-1:0] iter_cnt;
    logic [2:0]    state_dbg;

    modport master (
        output start, blk_valid, blk_data, nba_valid, nba_data,
        input  x, busy, done, loop_err, iter_cnt, state_dbg
    );

    modport slave (
        input  start, blk_valid, blk_data, nba_valid, nba_data,
        output x, busy, done, loop_err, iter_cnt, state_dbg
    );
endinterface

// File: rtl/vv_update_scheduler.sv
// Orders a blocking write, its watcher propagation, then a non-blocking write and its
// propagation into one shared register, with a bound on watcher iterations per step.
module vv_update_scheduler #(
    parameter int W              = 16,
    parameter int MAX_ITER       = 8,
    parameter int RETRIGGER_SELF = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vv_update_scheduler_if.slave  bus
);
    localparam int IW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_WATCH1 = 3'd2,
        S_NBA    = 3'd3,
        S_WATCH2 = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state;
    logic [W-1:0]  x_q;
    logic          x0_seen;
    logic          blk_v_q;
    logic [W-1:0]  blk_d_q;
    logic          nba_v_q;
    logic [W-1:0]  nba_d_q;
    logic [IW-1:0] iter_q;
    logic          err_q;
    logic          done_q;
    logic          busy_q;

    logic fire;
    logic at_limit;

    assign fire     = (x_q[0] != x0_seen);
    assign at_limit = (iter_q == IW'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            x_q     <= '0;
            x0_seen <= 1'b0;
            blk_v_q <= 1'b0;
            blk_d_q <= '0;
            nba_v_q <= 1'b0;
            nba_d_q <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        blk_v_q <= bus.blk_valid;
                        blk_d_q <= bus.blk_data;
                        nba_v_q <= bus.nba_valid;
                        nba_d_q <= bus.nba_data;
                        iter_q  <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (blk_v_q) x_q <= blk_d_q;
                    state <= S_WATCH1;
                end
                S_WATCH1, S_WATCH2: begin
                    if (fire && at_limit) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else if (fire) begin
                        x_q    <= x_q + W'(1);
                        iter_q <= iter_q + IW'(1);
                        // Faulty mode keeps the stale bit, so the fresh x[0] looks like a new change.
                        x0_seen <= (RETRIGGER_SELF != 0) ? x_q[0] : ~x_q[0];
                    end else if (state == S_WATCH1 && nba_v_q) begin
                        state <= S_NBA;
                    end else begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_NBA: begin
                    x_q     <= nba_d_q;
                    nba_v_q <= 1'b0;
                    state   <= S_WATCH2;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x         = x_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.loop_err  = err_q;
    assign bus.iter_cnt  = iter_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_vv_update_scheduler.sv
// Bench for vv_update_scheduler: three instances (W16 correct, W1 correct, W16 faulty)
// share one stimulus stream and are compared to a step-level reference model.
module tb_vv_update_scheduler;
    localparam int MAX_ITER = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        blk_valid;
    logic [15:0] blk_data;
    logic        nba_valid;
    logic [15:0] nba_data;

    int n_checks;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    vv_update_scheduler_if #(.W(16), .MAX_ITER(MAX_ITER)) if_r0 ();
    vv_update_scheduler_if #(.W(1),  .MAX_ITER(MAX_ITER)) if_w1 ();
    vv_update_scheduler_if #(.W(16), .MAX_ITER(MAX_ITER)) if_r1 ();

    vv_update_scheduler #(.W(16), .MAX_ITER(MAX_ITER), .RETRIGGER_SELF(0)) u_r0 (.clk(clk), .rst_n(rst_n), .bus(if_r0));
    vv_update_scheduler #(.W(1),  .MAX_ITER(MAX_ITER), .RETRIGGER_SELF(0)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));
    vv_update_scheduler #(.W(16), .MAX_ITER(MAX_ITER), .RETRIGGER_SELF(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1));

    assign if_r0.start = start;  assign if_w1.start = start;  assign if_r1.start = start;
    assign if_r0.blk_valid = blk_valid;  assign if_w1.blk_valid = blk_valid;  assign if_r1.blk_valid = blk_valid;
    assign if_r0.nba_valid = nba_valid;  assign if_w1.nba_valid = nba_valid;  assign if_r1.nba_valid = nba_valid;
    assign if_r0.blk_data = blk_data;    assign if_w1.blk_data = blk_data[0:0];  assign if_r1.blk_data = blk_data;
    assign if_r0.nba_data = nba_data;    assign if_w1.nba_data = nba_data[0:0];  assign if_r1.nba_data = nba_data;

    logic [15:0] x_v[3];
    logic [3:0]  iter_v[3];
    logic        done_v[3];
    logic        busy_v[3];
    logic        err_v[3];
    logic [2:0]  st_v[3];

    assign x_v[0] = if_r0.x;  assign x_v[1] = {15'd0, if_w1.x};  assign x_v[2] = if_r1.x;
    assign iter_v[0] = if_r0.iter_cnt;  assign iter_v[1] = if_w1.iter_cnt;  assign iter_v[2] = if_r1.iter_cnt;
    assign done_v[0] = if_r0.done;  assign done_v[1] = if_w1.done;  assign done_v[2] = if_r1.done;
    assign busy_v[0] = if_r0.busy;  assign busy_v[1] = if_w1.busy;  assign busy_v[2] = if_r1.busy;
    assign err_v[0] = if_r0.loop_err;  assign err_v[1] = if_w1.loop_err;  assign err_v[2] = if_r1.loop_err;
    assign st_v[0] = if_r0.state_dbg;  assign st_v[1] = if_w1.state_dbg;  assign st_v[2] = if_r1.state_dbg;

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] x;
        logic        seen;
        int          iter;
        logic        err;
    } mstate_t;

    mstate_t     m[3];
    logic [15:0] mask[3]    = '{16'hFFFF, 16'h0001, 16'hFFFF};
    bit          retrig[3]  = '{1'b0, 1'b0, 1'b1};
    logic [15:0] exp_q[$];
    int          last_lat[3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m[k].x = '0; m[k].seen = 1'b0; m[k].iter = 0; m[k].err = 1'b0;
        end
    endfunction

    // One watcher phase: returns cycles spent; aborted=1 when the increment budget runs out.
    function automatic int watch_phase(input int k, output bit aborted);
        int   cyc;
        logic b;
        cyc = 0;
        aborted = 1'b0;
        for (int guard = 0; guard <= MAX_ITER + 1; guard++) begin
            cyc++;
            if (m[k].x[0] == m[k].seen) break;
            if (m[k].iter == MAX_ITER) begin
                m[k].err = 1'b1;
                aborted = 1'b1;
                break;
            end
            b = m[k].x[0];
            m[k].x = (m[k].x + 16'd1) & mask[k];
            m[k].iter++;
            m[k].seen = retrig[k] ? b : ~b;
        end
        return cyc;
    endfunction

    // Latency counts clock edges from the accepting edge to the edge that raises done.
    function automatic int model_step(input int k, input bit bv, input logic [15:0] bd,
                                      input bit nv, input logic [15:0] nd);
        int lat;
        bit ab;
        m[k].iter = 0;
        m[k].err  = 1'b0;
        lat = 2;
        if (bv) m[k].x = bd & mask[k];
        lat += watch_phase(k, ab);
        if (!ab && nv) begin
            m[k].x = nd & mask[k];
            lat += 1 + watch_phase(k, ab);
        end
        return lat;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst%0d] got=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; blk_valid = 1'b0; blk_data = '0; nba_valid = 1'b0; nba_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_step(input bit bv, input logic [15:0] bd, input bit nv,
                            input logic [15:0] nd, input bit poke);
        int lat_exp[3];
        int first[3];
        int dcnt[3];
        int maxf;
        bit all_seen;
        @(negedge clk);
        start = 1'b1; blk_valid = bv; blk_data = bd; nba_valid = nv; nba_data = nd;
        for (int k = 0; k < 3; k++) begin
            lat_exp[k] = model_step(k, bv, bd, nv, nd);
            exp_q.push_back(m[k].x);
            first[k] = 0;
            dcnt[k] = 0;
        end
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                for (int k = 0; k < 3; k++) chk("busy_after_accept", k, 32'(busy_v[k]), 32'd1);
                if (poke) begin
                    // Second request while busy: must be dropped.
                    blk_valid = 1'b1; blk_data = 16'h5A5B; nba_valid = 1'b1; nba_data = 16'hA5A7;
                end else begin
                    start = 1'b0;
                end
            end else if (e == 2) begin
                start = 1'b0;
            end
            all_seen = 1'b1;
            maxf = 0;
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    dcnt[k]++;
                    if (first[k] == 0) first[k] = e;
                end
                if (first[k] == 0) all_seen = 1'b0;
                if (first[k] > maxf) maxf = first[k];
            end
            if (all_seen && e > maxf) break;
        end
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ex;
            ex = exp_q.pop_front();
            last_lat[k] = first[k];
            chk("latency", k, 32'(first[k]), 32'(lat_exp[k]));
            chk("done_pulses", k, 32'(dcnt[k]), 32'd1);
            chk("x", k, 32'(x_v[k]), 32'(ex));
            chk("iter_cnt", k, 32'(iter_v[k]), 32'(m[k].iter));
            chk("loop_err", k, 32'(err_v[k]), 32'(m[k].err));
            chk("busy_idle", k, 32'(busy_v[k]), 32'd0);
        end
    endtask

    // ---------------- directed vectors for the W16 correct instance ----------------
    typedef struct {
        bit          bv;
        logic [15:0] bd;
        bit          nv;
        logic [15:0] nd;
        logic [15:0] exp_x;
        int          exp_iter;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        start = 1'b0; blk_valid = 1'b0; blk_data = '0; nba_valid = 1'b0; nba_data = '0;

        // Sequential from reset; the watcher's seen bit carries over between rows.
        tbl[0] = '{1'b1, 16'd0,      1'b1, 16'd2, 16'd2,  0, 1'b0, 5};
        tbl[1] = '{1'b1, 16'd5,      1'b0, 16'd0, 16'd6,  1, 1'b0, 4};
        tbl[2] = '{1'b1, 16'd7,      1'b1, 16'd8, 16'd8,  1, 1'b0, 6};
        tbl[3] = '{1'b0, 16'd0,      1'b1, 16'd9, 16'd10, 1, 1'b0, 6};
        tbl[4] = '{1'b0, 16'd0,      1'b0, 16'd0, 16'd10, 0, 1'b0, 3};
        tbl[5] = '{1'b1, 16'hFFFF,   1'b0, 16'd0, 16'd0,  1, 1'b0, 4};
        tbl[6] = '{1'b1, 16'd3,      1'b1, 16'd5, 16'd6,  2, 1'b0, 7};

        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_x", k, 32'(x_v[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
            chk("rst_done", k, 32'(done_v[k]), 32'd0);
            chk("rst_err", k, 32'(err_v[k]), 32'd0);
            chk("rst_iter", k, 32'(iter_v[k]), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_step(tbl[i].bv, tbl[i].bd, tbl[i].nv, tbl[i].nd, 1'b0);
            chk("tbl_x", 0, 32'(x_v[0]), 32'(tbl[i].exp_x));
            chk("tbl_iter", 0, 32'(iter_v[0]), 32'(tbl[i].exp_iter));
            chk("tbl_err", 0, 32'(err_v[0]), 32'(tbl[i].exp_err));
            chk("tbl_lat", 0, 32'(last_lat[0]), 32'(tbl[i].exp_lat));
        end

        // W=1 wrap: NBA writes 1, watcher fires once and wraps to 0.
        do_reset();
        run_step(1'b0, 16'd0, 1'b1, 16'd1, 1'b0);
        chk("w1_x", 1, 32'(x_v[1]), 32'd0);
        chk("w1_iter", 1, 32'(iter_v[1]), 32'd1);
        chk("w1_err", 1, 32'(err_v[1]), 32'd0);
        chk("w1_r0_x", 0, 32'(x_v[0]), 32'd2);

        // Faulty watcher runs away from 3 up to 11 and aborts.
        do_reset();
        run_step(1'b0, 16'd0, 1'b1, 16'd3, 1'b0);
        chk("loop_x", 2, 32'(x_v[2]), 32'd11);
        chk("loop_iter", 2, 32'(iter_v[2]), 32'd8);
        chk("loop_err", 2, 32'(err_v[2]), 32'd1);
        chk("loop_lat", 2, 32'(last_lat[2]), 32'd13);

        // Clean step right after the aborted one clears loop_err.
        run_step(1'b1, 16'd2, 1'b1, 16'd2, 1'b0);
        chk("b2b_x", 2, 32'(x_v[2]), 32'd2);
        chk("b2b_iter", 2, 32'(iter_v[2]), 32'd0);
        chk("b2b_err", 2, 32'(err_v[2]), 32'd0);

        // Start held during a busy step must not disturb it.
        run_step(1'b0, 16'd0, 1'b1, 16'd4, 1'b1);
        chk("poke_x", 0, 32'(x_v[0]), 32'd4);

        // Reset in WATCH2 aborts the step without a done pulse.
        begin
            bit reached;
            int dseen;
            reached = 1'b0;
            dseen = 0;
            do_reset();
            @(negedge clk);
            start = 1'b1; blk_valid = 1'b0; blk_data = '0; nba_valid = 1'b1; nba_data = 16'd4;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 10 && !reached; c++) begin
                @(posedge clk); #1;
                if (st_v[0] == 3'd4) reached = 1'b1;
            end
            chk("reach_watch2", 0, 32'(reached), 32'd1);
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("midrst_x", k, 32'(x_v[k]), 32'd0);
                chk("midrst_busy", k, 32'(busy_v[k]), 32'd0);
                chk("midrst_err", k, 32'(err_v[k]), 32'd0);
                chk("midrst_state", k, 32'(st_v[k]), 32'd0);
            end
            repeat (2) begin
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++) if (done_v[k]) dseen++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            repeat (4) begin
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++) if (done_v[k]) dseen++;
            end
            chk("midrst_no_done", 0, 32'(dseen), 32'd0);
        end

        // Randomized steps against the model.
        for (int i = 0; i < 30; i++) begin
            bit          bv;
            bit          nv;
            logic [15:0] bd;
            logic [15:0] nd;
            bv = 1'($urandom_range(0, 1));
            nv = 1'($urandom_range(0, 1));
            bd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            nd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            run_step(bv, bd, nv, nd, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
